// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the vernier-buffer TDC sweep controller:
//   - tdc_state_e        : sequencer states (IDLE/ARM/FIRE/CAPT/OUT)
//   - tdc_cw()           : tap-count width for a given thermometer width
//   - TDC_SETTLE_DEFAULT : default ARM-phase length in cycles
// No ports (package).
// -----------------------------------------------------------------------------
package tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_FIRE = 3'd2,
    ST_CAPT = 3'd3,
    ST_OUT  = 3'd4
  } tdc_state_e;

  localparam int TDC_SETTLE_DEFAULT = 4;

  // Bits needed to hold a tap count in 0..taps inclusive.
  function automatic int tdc_cw(input int taps);
    return $clog2(taps + 1);
  endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// -----------------------------------------------------------------------------
// tdc_therm_decode
// Combinational thermometer-to-count decoder for the TDC core output.
//   Default build          : count = number of ones in term (popcount).
//   TDC_BUBBLE_FIX_EN      : count = index of the lowest 0 bit, or TAPS when
//                            term is all ones; bubbles above that 0 are ignored.
// Ports:
//   term   in  TAPS  synchronised thermometer code
//   count  out CW    decoded tap count
// -----------------------------------------------------------------------------
module tdc_therm_decode
  import tdc_pkg::*;
#(
  parameter int TAPS = 8,
  parameter int CW   = tdc_cw(TAPS)
) (
  input  logic [TAPS-1:0] term,
  output logic [CW-1:0]   count
);

`ifdef TDC_BUBBLE_FIX_EN
  // Scan downward so the last assignment wins with the lowest zero index.
  always_comb begin
    count = CW'(TAPS);
    for (int i = TAPS - 1; i >= 0; i--) begin
      count = term[i] ? count : CW'(i);
    end
  end
`else
  // Plain popcount of the thermometer word.
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < TAPS; i++) begin
      count = count + CW'(term[i]);
    end
  end
`endif

endmodule

// File: rtl/tdc_sweep_controller.sv
// -----------------------------------------------------------------------------
// tdc_sweep_controller
// Autonomous delay-code sweep for the vernier-buffer TDC. For each delay code
// 0..DLY_MAX it runs 2^AVG_LOG2 measurements (ARM -> FIRE -> CAPT), sums the
// decoded tap counts and offers the sum on a valid/ready port.
// Optional feature macro: TDC_BUBBLE_FIX_EN (selects the bubble-tolerant
// decode inside tdc_therm_decode; timing is unchanged).
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   start_i      in   begin a sweep (honoured only when idle)
//   abort_i      in   synchronous abort back to idle, drops pending result
//   term_i       in   asynchronous thermometer code from the TDC core
//   dly_code_o   out  delay code to the variable-delay macro
//   fire_o       out  launch level, high throughout the FIRE phase
//   busy_o       out  high whenever not idle
//   res_valid_o  out  result valid
//   res_ready_i  in   result accepted
//   res_code_o   out  delay code of the presented result
//   res_sum_o    out  sum of tap counts for that code
//   done_o       out  one-cycle pulse after the final handshake
// All outputs are registered from next-state values.
// -----------------------------------------------------------------------------
module tdc_sweep_controller
  import tdc_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int DLY_BITS = 5,
  parameter int DLY_MAX  = (1 << DLY_BITS) - 1,
  parameter int AVG_LOG2 = 2,
  parameter int SETTLE   = TDC_SETTLE_DEFAULT,
  localparam int CW      = tdc_cw(TAPS),
  localparam int SW      = CW + AVG_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [TAPS-1:0]     term_i,
  output logic [DLY_BITS-1:0] dly_code_o,
  output logic                fire_o,
  output logic                busy_o,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [DLY_BITS-1:0] res_code_o,
  output logic [SW-1:0]       res_sum_o,
  output logic                done_o
);

  // Phase counter must reach SETTLE+1 (last FIRE cycle).
  localparam int CNT_W = $clog2(SETTLE + 2);
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam int N_SMP = 1 << AVG_LOG2;

  tdc_state_e          state_r, state_s;
  logic [TAPS-1:0]     sync1_r, sync2_r;
  logic [CW-1:0]       tap_count_s;
  logic [CNT_W-1:0]    phase_r, phase_s;
  logic [SMP_W-1:0]    smp_r, smp_s;
  logic [SW-1:0]       acc_r, acc_s, acc_sum_s;
  logic [DLY_BITS-1:0] dly_code_s, res_code_s;
  logic [SW-1:0]       res_sum_s;
  logic                done_s;

  tdc_therm_decode #(
    .TAPS (TAPS),
    .CW   (CW)
  ) u_decode (
    .term  (sync2_r),
    .count (tap_count_s)
  );

  assign acc_sum_s = acc_r + SW'(tap_count_s);

  // Two-flop synchroniser for the asynchronous thermometer word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= {TAPS{1'b0}};
      sync2_r <= {TAPS{1'b0}};
    end else begin
      sync1_r <= term_i;
      sync2_r <= sync1_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-datapath logic; abort overrides everything.
  always_comb begin
    state_s    = state_r;
    phase_s    = phase_r;
    smp_s      = smp_r;
    acc_s      = acc_r;
    dly_code_s = dly_code_o;
    res_code_s = res_code_o;
    res_sum_s  = res_sum_o;
    done_s     = 1'b0;
    if (abort_i) begin
      state_s = ST_IDLE;
      phase_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_s    = ST_ARM;
            dly_code_s = {DLY_BITS{1'b0}};
            acc_s      = {SW{1'b0}};
            smp_s      = {SMP_W{1'b0}};
            phase_s    = {CNT_W{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (phase_r == CNT_W'(SETTLE - 1)) begin
            state_s = ST_FIRE;
            phase_s = {CNT_W{1'b0}};
          end else begin
            phase_s = phase_r + CNT_W'(1);
          end
        end
        ST_FIRE: begin
          if (phase_r == CNT_W'(SETTLE + 1)) begin
            state_s = ST_CAPT;
            phase_s = {CNT_W{1'b0}};
          end else begin
            phase_s = phase_r + CNT_W'(1);
          end
        end
        ST_CAPT: begin
          acc_s = acc_sum_s;
          smp_s = smp_r + SMP_W'(1);
          if (smp_r == SMP_W'(N_SMP - 1)) begin
            // Latch the result here so it is stable for the whole OUT phase.
            state_s    = ST_OUT;
            res_code_s = dly_code_o;
            res_sum_s  = acc_sum_s;
          end else begin
            state_s = ST_ARM;
          end
        end
        ST_OUT: begin
          if (res_ready_i) begin
            if (dly_code_o == DLY_BITS'(DLY_MAX)) begin
              state_s = ST_IDLE;
              done_s  = 1'b1;
            end else begin
              state_s    = ST_ARM;
              dly_code_s = dly_code_o + DLY_BITS'(1);
              acc_s      = {SW{1'b0}};
              smp_s      = {SMP_W{1'b0}};
              phase_s    = {CNT_W{1'b0}};
            end
          end else begin
            state_s = ST_OUT;
          end
        end
        default: begin
          state_s = ST_IDLE;
          phase_s = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered outputs and datapath, derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_code_o  <= {DLY_BITS{1'b0}};
      fire_o      <= 1'b0;
      busy_o      <= 1'b0;
      res_valid_o <= 1'b0;
      res_code_o  <= {DLY_BITS{1'b0}};
      res_sum_o   <= {SW{1'b0}};
      done_o      <= 1'b0;
      phase_r     <= {CNT_W{1'b0}};
      smp_r       <= {SMP_W{1'b0}};
      acc_r       <= {SW{1'b0}};
    end else begin
      dly_code_o  <= dly_code_s;
      fire_o      <= (state_s == ST_FIRE);
      busy_o      <= (state_s != ST_IDLE);
      res_valid_o <= (state_s == ST_OUT);
      res_code_o  <= res_code_s;
      res_sum_o   <= res_sum_s;
      done_o      <= done_s;
      phase_r     <= phase_s;
      smp_r       <= smp_s;
      acc_r       <= acc_s;
    end
  end

endmodule

// File: tb/tb_tdc_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_tdc_sweep_controller
// Self-checking bench for tdc_sweep_controller with default parameters.
// Expected values come from a behavioural model: a sample lasts 2*SETTLE+3
// cycles, FIRE is phase SETTLE..2*SETTLE+1 of a sample, each code's sum is
// 2^AVG_LOG2 times the tap count of the thermometer word applied for it.
// Outputs are sampled and inputs driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tdc_sweep_controller;

  localparam int TAPS        = 8;
  localparam int DLY_BITS    = 5;
  localparam int DLY_MAX     = 31;
  localparam int AVG_LOG2    = 2;
  localparam int SETTLE      = 4;
  localparam int SW          = 6;
  localparam int N_SMP       = 1 << AVG_LOG2;
  localparam int SAMPLE_CYC  = 2 * SETTLE + 3;
  localparam int FIRST_VALID = N_SMP * SAMPLE_CYC + 1;
  localparam int TIMEOUT     = 5000;

  localparam int M_FIXED     = 0;
  localparam int M_RAND      = 1;
  localparam int M_BP        = 2;
  localparam int M_BUSYSTART = 3;
  localparam int M_ABORT     = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i;
  logic                abort_i;
  logic [TAPS-1:0]     term_i;
  logic [DLY_BITS-1:0] dly_code_o;
  logic                fire_o;
  logic                busy_o;
  logic                res_valid_o;
  logic                res_ready_i;
  logic [DLY_BITS-1:0] res_code_o;
  logic [SW-1:0]       res_sum_o;
  logic                done_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdc_sweep_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .term_i      (term_i),
    .dly_code_o  (dly_code_o),
    .fire_o      (fire_o),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_code_o  (res_code_o),
    .res_sum_o   (res_sum_o),
    .done_o      (done_o)
  );

  // Tap count of one thermometer word as the core defines it.
  function automatic int tap_model(input logic [TAPS-1:0] t);
    int n;
`ifdef TDC_BUBBLE_FIX_EN
    n = 0;
    while (n < TAPS && t[n]) n++;
`else
    n = $countones(t);
`endif
    return n;
  endfunction

  function automatic int pick_stall(input int mode, input int code);
    if (mode == M_BP) return (code == 3) ? 10 : 0;
    if (mode == M_RAND) return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dly"},   dly_code_o,  0);
    chk({tag, "_fire"},  fire_o,      0);
    chk({tag, "_busy"},  busy_o,      0);
    chk({tag, "_valid"}, res_valid_o, 0);
    chk({tag, "_rcode"}, res_code_o,  0);
    chk({tag, "_rsum"},  res_sum_o,   0);
    chk({tag, "_done"},  done_o,      0);
  endtask

  // Run one sweep from IDLE; entered and left just after a falling edge.
  task automatic sweep(input int mode, input logic [TAPS-1:0] fixed_term);
    int cyc, exp_code, exp_sum, stall, p;
    bit first_seen, last_hs, fin, fire_prev, abort_arm, abort_sent;
    logic [TAPS-1:0] cur_term;
    cur_term   = (mode == M_RAND) ? TAPS'($urandom) : fixed_term;
    term_i     = cur_term;
    exp_code   = 0;
    exp_sum    = N_SMP * tap_model(cur_term);
    stall      = pick_stall(mode, 0);
    first_seen = 1'b0; last_hs = 1'b0; fin = 1'b0;
    fire_prev  = 1'b0; abort_arm = 1'b0; abort_sent = 1'b0;
    start_i    = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!fin && cyc <= TIMEOUT) begin
      if (abort_sent) begin
        chk("abort_fire",  fire_o,      0);
        chk("abort_busy",  busy_o,      0);
        chk("abort_valid", res_valid_o, 0);
        chk("abort_done",  done_o,      0);
        abort_i = 1'b0;
        for (int q = 0; q < 30; q++) begin
          @(negedge clk);
          chk("quiet_busy",  busy_o,      0);
          chk("quiet_valid", res_valid_o, 0);
          chk("quiet_done",  done_o,      0);
        end
        fin = 1'b1;
      end else if (last_hs) begin
        chk("done_pulse", done_o,      1);
        chk("done_busy",  busy_o,      0);
        chk("done_valid", res_valid_o, 0);
        res_ready_i = 1'b0;
        fin = 1'b1;
      end else begin
        chk("busy",     busy_o,     1);
        chk("no_done",  done_o,     0);
        chk("dly_code", dly_code_o, exp_code);
        if (cyc < FIRST_VALID) begin
          p = (cyc - 1) % SAMPLE_CYC;
          chk("fire_phase",  fire_o,      (p >= SETTLE && p <= 2 * SETTLE + 1));
          chk("early_valid", res_valid_o, 0);
        end
        if (mode == M_ABORT) begin
          if (abort_arm) begin
            chk("abort_fire2", fire_o, 1);
            abort_i    = 1'b1;
            abort_sent = 1'b1;
            abort_arm  = 1'b0;
          end else if (fire_o && !fire_prev && exp_code == 5) begin
            abort_arm = 1'b1;
          end
        end
        if (mode == M_BUSYSTART) start_i = (cyc == 20) || (res_valid_o && exp_code == 10);
        if (res_valid_o) begin
          if (!first_seen) begin
            chk("first_valid_cycle", cyc, FIRST_VALID);
            first_seen = 1'b1;
          end
          chk("res_code", res_code_o, exp_code);
          chk("res_sum",  res_sum_o,  exp_sum);
          if (stall > 0) begin
            res_ready_i = 1'b0;
            chk("stall_fire", fire_o, 0);
            stall--;
          end else begin
            res_ready_i = 1'b1;
            if (exp_code == DLY_MAX) begin
              last_hs = 1'b1;
            end else begin
              exp_code++;
              if (mode == M_RAND) cur_term = TAPS'($urandom);
              term_i  = cur_term;
              exp_sum = N_SMP * tap_model(cur_term);
              stall   = pick_stall(mode, exp_code);
            end
          end
        end else begin
          res_ready_i = 1'b0;
        end
        fire_prev = fire_o;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("sweep_finished", fin, 1);
    start_i     = 1'b0;
    res_ready_i = 1'b0;
    abort_i     = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b1;
    abort_i     = 1'b0;
    res_ready_i = 1'b0;
    term_i      = 8'h00;

    // Reset held with start asserted: everything stays at zero.
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("reset");
    end
    rst_n   = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("idle_fire", fire_o, 0);

    sweep(M_FIXED,     8'b0000_0111);
    sweep(M_BP,        8'b0000_0111);
    sweep(M_FIXED,     8'b0000_1011);
    sweep(M_ABORT,     8'b0000_0111);
    sweep(M_RAND,      8'h00);
    sweep(M_BUSYSTART, 8'hFF);
    sweep(M_RAND,      8'h00);

    // Reset in the middle of the first FIRE phase.
    term_i  = 8'b0000_0111;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_fire", fire_o, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy_o, 0);
    chk("post_reset_fire", fire_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_sweep_controller.md
# tdc_sweep_controller

Digital sequencer and readout for the vernier-buffer TDC. It steps the stop-path variable-delay code across a programmable range and launches repeated start/stop edges into the analog core. It captures and synchronises the TAPS-wide thermometer output, decodes it to a tap count, and sums 2^AVG_LOG2 samples per delay code. Each per-code sum is returned on a valid/ready result port. It sits between the tile I/O and the analog TDC/delay macros, and generalises the fixed 8-tap, pin-driven measurement into an autonomous, parametrised delay sweep.

## Interface
Parameters:
- TAPS, 8 — thermometer width from the TDC core.
- DLY_BITS, 5 — width of the variable-delay enable code.
- DLY_MAX, 2^DLY_BITS-1 — last delay code in a sweep, inclusive.
- AVG_LOG2, 2 — log2 of the number of samples summed per code.
- SETTLE, 4 — length of the ARM phase in cycles; the FIRE phase is SETTLE+2 cycles.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  synchronous, active-low reset.
- start_i  in  1  begins a sweep; sampled only in IDLE.
- abort_i  in  1  synchronous abort; has priority over all other inputs except reset.
- term_i  in  TAPS  asynchronous thermometer code from the TDC core.
- dly_code_o  out  DLY_BITS  delay code driven to the variable-delay macro.
- fire_o  out  1  launch level to the input stages; the rising edge starts a measurement.
- busy_o  out  1  high in every state except IDLE.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result accepted.
- res_code_o  out  DLY_BITS  delay code that the result belongs to.
- res_sum_o  out  CW+AVG_LOG2  sum of the per-sample tap counts, where CW = clog2(TAPS+1).
- done_o  out  1  one-cycle pulse when the sweep completes.

## Operation
- States: IDLE, ARM, FIRE, CAPT, OUT.
- IDLE:
  - If start_i=1: go to ARM, set dly_code_o=0, clear the accumulator and the sample counter.
  - If start_i=0: stay in IDLE.
- ARM: fire_o=0 for SETTLE cycles, then go to FIRE.
- FIRE: fire_o=1 for SETTLE+2 cycles, then go to CAPT. The extra 2 cycles cover the synchroniser.
- CAPT (1 cycle):
  - Decode the 2-flop-synchronised term, add it to the accumulator, increment the sample counter.
  - If the counter reaches 2^AVG_LOG2, go to OUT; otherwise go to ARM.
- OUT:
  - res_valid_o=1. res_code_o and res_sum_o are registered and held stable until the handshake.
  - On res_valid_o & res_ready_i:
    - If dly_code_o==DLY_MAX: go to IDLE and pulse done_o for the next cycle.
    - Otherwise: increment dly_code_o, clear the accumulator and counter, go to ARM.
- Decode (default): tap count = popcount(term).
- Arithmetic: all unsigned. The accumulator is CW+AVG_LOG2 bits and cannot overflow, since the maximum is TAPS·2^AVG_LOG2.
- start_i outside IDLE is ignored.
- abort_i=1 in any state: next cycle the block is in IDLE with fire_o=0 and res_valid_o=0. No done_o pulse is issued, and any pending result is dropped.
- Reset (including mid-sweep): all outputs go to 0, state goes to IDLE, and the synchroniser flops are cleared.
- DLY_MAX=0: a sweep produces exactly one result.

## Timing
- Reset values: dly_code_o=0, fire_o=0, busy_o=0, res_valid_o=0, res_code_o=0, res_sum_o=0, done_o=0.
- Count cycles from the edge that samples start_i=1 (cycle 0):
  - ARM occupies cycles 1..SETTLE.
  - FIRE occupies the next SETTLE+2 cycles.
  - CAPT is 1 cycle.
  - One sample therefore takes 2·SETTLE+3 cycles, which is 11 with defaults.
- The first res_valid_o is high at cycle 2^AVG_LOG2·(2·SETTLE+3)+1, which is 45 with defaults.
- After a handshake that is not the last one, ARM starts on the next cycle.
- done_o goes high the cycle after the final handshake; busy_o is low in that same cycle.
- All outputs are registered.

## Configuration
- TDC_BUBBLE_FIX_EN defined:
  - Tap count = index of the first 0 bit scanning up from bit 0, or TAPS if all bits are 1.
  - Bubbles above the first 0 are ignored.
- TDC_BUBBLE_FIX_EN undefined: tap count = popcount(term).
- Cycle timing is identical in both configurations.

## Structure
- Shared package tdc_pkg holds:
  - the state enum (IDLE/ARM/FIRE/CAPT/OUT);
  - the function computing CW from TAPS;
  - the default SETTLE constant.
- Sub-module tdc_therm_decode: combinational TAPS→CW decoder. It contains the TDC_BUBBLE_FIX_EN selection.
- The synchroniser, FSM, sample counter and accumulator live in the top.

## Test plan
- Reset: hold rst_n=0 through 3 clocks while start_i=1 → all outputs 0, no fire_o activity.
- Full sweep, defaults, term_i held at 8'b0000_0111, res_ready_i=1 → 32 results:
  - res_code_o 0..31 in order, each res_sum_o=12;
  - first res_valid_o at cycle 45;
  - done_o pulses once after code 31.
- Backpressure: res_ready_i=0 for 10 cycles at code 3 → res_valid_o held, res_code_o=3 and res_sum_o stable, fire_o stays 0, dly_code_o does not advance.
- Bubble, term_i=8'b0000_1011 → res_sum_o=12 without TDC_BUBBLE_FIX_EN, 8 with it.
- Abort in the 2nd FIRE cycle of code 5 → fire_o=0, busy_o=0 and state IDLE next cycle, no res_valid_o, no done_o. A fresh start_i then restarts at code 0.
- start_i pulsed while busy with term_i all ones → ignored; sums are 32 and the code sequence is unchanged.
